// File: rtl/priority_decoder_seq.sv
// priority_decoder_seq: receiving end of a 4-input priority encoder.
// Takes one {valid, code} request per handshake and turns it into a one-hot
// grant. The grant is held for a minimum number of cycles. After that the
// block waits for the consumer's ack, and gives up after a bounded timeout.
module priority_decoder_seq #(
   parameter int unsigned HOLD_CYCLES    = 4,   // 1..255
   parameter int unsigned TIMEOUT_CYCLES = 16   // 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] in_code,
   output logic       in_ready,
   output logic [3:0] grant,
   output logic       grant_valid,
   input  logic       ack,
   output logic       busy,
   output logic       timeout,
   output logic [7:0] timeout_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_ACK = 2'd2
   } state_e;

   // Timers count down to zero, so they load with N-1.
   localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] TO_INIT   = 8'(TIMEOUT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] grant_q, grant_d;
   logic       grant_valid_q, grant_valid_d;
   logic       busy_q, busy_d;
   logic       timeout_q, timeout_d;
   logic [7:0] timeout_cnt_q, timeout_cnt_d;
   logic [7:0] hold_timer_q, hold_timer_d;
   logic [7:0] to_timer_q, to_timer_d;
   logic       ack_seen_q, ack_seen_d;

   // Next-state and next-output logic for the IDLE -> HOLD -> WAIT_ACK sequence.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      hold_timer_d  = hold_timer_q;
      to_timer_d    = to_timer_q;
      ack_seen_d    = ack_seen_q;
      timeout_d     = 1'b0;
      timeout_cnt_d = timeout_cnt_q;

      case (state_q)
         IDLE: begin
            // in_ready is 1 here, so in_valid alone completes the handshake.
            if (in_valid) begin
               state_d       = HOLD;
               grant_d       = 4'b0001 << in_code;
               grant_valid_d = 1'b1;
               hold_timer_d  = HOLD_INIT;
               ack_seen_d    = 1'b0;
            end
         end

         HOLD: begin
            // An ack seen early is remembered so the grant can drop right after HOLD.
            ack_seen_d = ack_seen_q | ack;
            if (hold_timer_q == 8'd0) begin
               if (ack_seen_q | ack) begin
                  state_d       = IDLE;
                  grant_d       = 4'b0000;
                  grant_valid_d = 1'b0;
               end else begin
                  state_d    = WAIT_ACK;
                  to_timer_d = TO_INIT;
               end
            end else begin
               hold_timer_d = hold_timer_q - 8'd1;
            end
         end

         WAIT_ACK: begin
            // If ack arrives on the same edge that the timer expires, ack takes priority.
            if (ack) begin
               state_d       = IDLE;
               grant_d       = 4'b0000;
               grant_valid_d = 1'b0;
            end else if (to_timer_q == 8'd0) begin
               state_d       = IDLE;
               grant_d       = 4'b0000;
               grant_valid_d = 1'b0;
               timeout_d     = 1'b1;
               if (timeout_cnt_q != 8'hFF)
                  timeout_cnt_d = timeout_cnt_q + 8'd1;
            end else begin
               to_timer_d = to_timer_q - 8'd1;
            end
         end

         default: begin
            state_d       = IDLE;
            grant_d       = 4'b0000;
            grant_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs; reset drops any grant immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= 4'b0000;
         grant_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
         timeout_cnt_q <= 8'd0;
         hold_timer_q  <= 8'd0;
         to_timer_q    <= 8'd0;
         ack_seen_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         busy_q        <= busy_d;
         timeout_q     <= timeout_d;
         timeout_cnt_q <= timeout_cnt_d;
         hold_timer_q  <= hold_timer_d;
         to_timer_q    <= to_timer_d;
         ack_seen_q    <= ack_seen_d;
      end
   end

   // in_ready is combinational, so the encoder can see it within the same cycle.
   assign in_ready    = (state_q == IDLE);
   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign busy        = busy_q;
   assign timeout     = timeout_q;
   assign timeout_cnt = timeout_cnt_q;

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Testbench for priority_decoder_seq. It checks the DUT cycle by cycle against
// a transaction-level model. The model tracks each grant by how many cycles it
// has been visible (its age) instead of by FSM state.
module tb_priority_decoder_seq;
   localparam int H = 4;
   localparam int T = 16;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_code  = 2'd0;
   logic       ack      = 1'b0;
   logic       in_ready, grant_valid, busy, timeout;
   logic [3:0] grant;
   logic [7:0] timeout_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   priority_decoder_seq #(.HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
      .in_ready(in_ready), .grant(grant), .grant_valid(grant_valid),
      .ack(ack), .busy(busy), .timeout(timeout), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   // Reference model. A grant that has been visible for 'age' cycles ends
   // once age >= H and an ack has been seen at any point during it. If no ack
   // arrives, it ends with a timeout when age reaches H+T.
   typedef struct {
      bit       active;
      bit [1:0] code;
      int       age;
      bit       acked;
      bit       to;
      int       cnt;
   } model_t;
   model_t m;

   function automatic model_t model_next(model_t s, bit v, bit [1:0] c, bit a);
      model_t n = s;
      n.to = 1'b0;
      if (s.active) begin
         n.age   = s.age + 1;
         n.acked = s.acked | a;
         if (n.age >= H && n.acked) n.active = 1'b0;
         else if (n.age == H + T) begin
            n.active = 1'b0;
            n.to     = 1'b1;
            if (n.cnt < 255) n.cnt = n.cnt + 1;
         end
      end else if (v) begin
         n.active = 1'b1;
         n.code   = c;
         n.age    = 0;
         n.acked  = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) m <= '{default: 0};
      else        m <= model_next(m, in_valid, in_code, ack);

   function automatic logic [15:0] exp_vec();
      logic [3:0] g = m.active ? 4'(1 << m.code) : 4'd0;
      return {g, m.active, m.active, !m.active, m.to, 8'(m.cnt)};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {grant, grant_valid, busy, in_ready, timeout, timeout_cnt};
   endfunction

   localparam logic [15:0] RESET_VEC = {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; ack = 1'b0;
      #2;
      n_cmp++;
      if (obs_vec() !== RESET_VEC) begin
         n_bad++; $display("FAIL reset_initial got=%h want=%h", obs_vec(), RESET_VEC);
      end
      @(negedge clk); rst_n = 1'b1; in_valid = 1'b1; in_code = 2'b10;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (grant !== 4'b0100) begin
         n_bad++; $display("FAIL mid_hold_grant got=%b want=0100", grant);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (obs_vec() !== RESET_VEC) begin
         n_bad++; $display("FAIL reset_mid_hold got=%h want=%h", obs_vec(), RESET_VEC);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_hold_ack_held();
      int gcnt;
      gcnt = 0;
      ack = 1'b1; in_valid = 1'b1; in_code = 2'b10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL hold_ack cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
         if (grant === 4'b0100) gcnt++;
      end
      ack = 1'b0;
      n_cmp++;
      if (gcnt != H) begin
         n_bad++; $display("FAIL hold_ack_len got=%0d want=%0d", gcnt, H);
      end
   endtask

   task automatic test_code_sweep();
      for (int k = 0; k < 4; k++) begin
         int gcnt, tos;
         logic [3:0] first;
         gcnt = 0; tos = 0; first = 4'd0;
         in_valid = 1'b1; in_code = 2'(k);
         for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++; $display("FAIL sweep k=%0d cyc=%0d got=%h want=%h", k, i, obs_vec(), exp_vec());
            end
            if (grant !== 4'd0) begin
               gcnt++;
               if (first == 4'd0) first = grant;
            end
            if (timeout) tos++;
            in_valid = 1'b0;
            ack = (i == 1);
         end
         ack = 1'b0;
         n_cmp++;
         if (first !== 4'(1 << k) || gcnt != H || tos != 0) begin
            n_bad++;
            $display("FAIL sweep_grant k=%0d got=%b/%0d/%0d want=%b/%0d/0", k, first, gcnt, tos, 4'(1 << k), H);
         end
      end
   endtask

   task automatic test_late_ack();
      int gcnt, tos;
      gcnt = 0; tos = 0;
      in_valid = 1'b1; in_code = 2'b11;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL late_ack cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
         if (grant === 4'b1000) gcnt++;
         if (timeout) tos++;
         ack = (i == H + 4);
      end
      ack = 1'b0;
      n_cmp++;
      if (gcnt != H + 4 || tos != 0) begin
         n_bad++; $display("FAIL late_ack_len got=%0d/%0d want=%0d/0", gcnt, tos, H + 4);
      end
   endtask

   task automatic test_timeout_saturate();
      int gcnt, tos;
      rst_n = 1'b0; in_valid = 1'b0; ack = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      in_valid = 1'b1; in_code = 2'($urandom_range(0, 3));
      for (int r = 0; r < 300; r++) begin
         gcnt = 0; tos = 0;
         for (int j = 1; j <= H + T + 1; j++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
               n_bad++; $display("FAIL timeout r=%0d cyc=%0d got=%h want=%h", r, j, obs_vec(), exp_vec());
            end
            if (grant_valid) gcnt++;
            if (timeout) tos++;
         end
         n_cmp++;
         if (gcnt != H + T || tos != 1) begin
            n_bad++; $display("FAIL timeout_shape r=%0d got=%0d/%0d want=%0d/1", r, gcnt, tos, H + T);
         end
         if (r == 0) begin
            n_cmp++;
            if (timeout_cnt !== 8'd1) begin
               n_bad++; $display("FAIL timeout_cnt_first got=%0d want=1", timeout_cnt);
            end
         end
         in_valid = 1'b1; in_code = 2'($urandom_range(0, 3));
      end
      in_valid = 1'b0;
      n_cmp++;
      if (timeout_cnt !== 8'd255) begin
         n_bad++; $display("FAIL timeout_cnt_sat got=%0d want=255", timeout_cnt);
      end
   endtask

   task automatic test_valid_held();
      logic [3:0] prev_g;
      prev_g = 4'd0;
      in_valid = 1'b1;
      for (int i = 0; i < 400; i++) begin
         in_code = 2'($urandom_range(0, 3));
         ack = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL valid_held cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
         if (prev_g != 4'd0 && grant != 4'd0) begin
            n_cmp++;
            if (grant !== prev_g) begin
               n_bad++; $display("FAIL grant_changed cyc=%0d got=%b want=%b", i, grant, prev_g);
            end
         end
         prev_g = grant;
      end
      in_valid = 1'b0; ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 1000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_code  = 2'($urandom_range(0, 3));
         ack      = ($urandom_range(0, 5) == 0);
         @(negedge clk);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
         n_cmp++;
         if ((grant_valid && !$onehot(grant)) || (!grant_valid && grant != 4'd0)) begin
            n_bad++; $display("FAIL onehot cyc=%0d got=%b/%b want=onehot-or-zero", i, grant_valid, grant);
         end
      end
      in_valid = 1'b0; ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_hold_ack_held();
      test_code_sweep();
      test_late_ack();
      test_timeout_saturate();
      test_valid_held();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
